// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ERROR = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_perf_counter.sv
// Free-running 32-bit event counter that wraps at 2^32.
module fetch_perf_counter
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    output logic [XLEN-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= count + XLEN'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Front-end fetch sequencer: addresses a 1-cycle synchronous instruction memory and
// hands the returned word to decode. fetch_valid/fetch_ready: a word transfers on any edge where both are high.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            halt,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] current_pc,
    input  logic [XLEN-1:0] instruction,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] fetch_instr,
    output logic [XLEN-1:0] fetch_pc,
    output logic            misalign_err,
    output logic [XLEN-1:0] fetch_count,
    output logic [XLEN-1:0] stall_count,
    output logic [1:0]      state_dbg
);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] addr_next;
    logic            valid_q;
    logic            valid_next;
    logic            err_set;
    logic            in_fetch;

    // pc_q always tracks the address the memory sampled, so instruction == imem[pc_q].
    always_comb begin
        state_next = state;
        addr_next  = pc_q;
        valid_next = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                    valid_next = 1'b1;
                end
            end
            FETCH: begin
                valid_next = 1'b1;
                if (halt) begin
                    state_next = IDLE;
                    valid_next = 1'b0;
                end else if (redirect_valid) begin
                    if (redirect_pc[1:0] == 2'b00) begin
                        addr_next = redirect_pc;
                    end else begin
                        state_next = ERROR;
                        valid_next = 1'b0;
                        err_set    = 1'b1;
                    end
                end else if (fetch_ready) begin
                    addr_next = pc_q + PC_STEP;
                end
            end
            default: begin
                state_next = state;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pc_q         <= RESET_PC;
            valid_q      <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state   <= state_next;
            pc_q    <= addr_next;
            valid_q <= valid_next;
            if (err_set) begin
                misalign_err <= 1'b1;
            end
        end
    end

    assign current_pc  = addr_next;
    assign fetch_pc    = pc_q;
    assign fetch_valid = valid_q;
    assign fetch_instr = instruction;
    assign state_dbg   = state;
    assign in_fetch    = (state == FETCH) && valid_q;

    fetch_perf_counter u_fetch_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (in_fetch && fetch_ready),
        .count (fetch_count)
    );

    fetch_perf_counter u_stall_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (in_fetch && !fetch_ready),
        .count (stall_count)
    );

endmodule
